// File: rtl/fifo_burst_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_burst_ctrl
// Sequencer wrapped around an 8x256 single-clock FIFO whose q is valid one
// cycle after rdreq. It passes source bytes into the FIFO and drops them while
// the FIFO is full, recording each drop in a sticky overflow flag. Once
// BURST_LEN bytes are buffered it drains exactly BURST_LEN bytes as one read
// burst, then holds off for GAP_CYCLES idle cycles. A flush pulse arms a
// pending request that drains whatever is left, in bursts of up to BURST_LEN.
//
// Parameters
//   BURST_LEN    bytes per read burst and fill threshold (1..256)
//   GAP_CYCLES   idle cycles forced after each burst (0..255, 0 = no gap)
//
// Ports
//   sys_clk, sys_rst_n          clock, asynchronous active-low reset
//   in_valid, in_data           byte source (no backpressure)
//   flush                       1-cycle pulse: drain FIFO to empty
//   ovf_clr                     clears the sticky overflow flag
//   fifo_wr_req, fifo_wr_data   FIFO write side
//   fifo_rd_req                 FIFO read request (registered)
//   fifo_q, fifo_empty,
//   fifo_full, fifo_usedw       FIFO read data and status
//   out_valid, out_data,
//   out_last                    byte sink; out_last marks the end of a burst
//   busy                        high while bursting or in the post-burst gap
//   overflow                    sticky: at least one write was dropped
// -----------------------------------------------------------------------------
module fifo_burst_ctrl #(
  parameter int BURST_LEN  = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       flush,
  input  logic       ovf_clr,
  output logic       fifo_wr_req,
  output logic [7:0] fifo_wr_data,
  output logic       fifo_rd_req,
  input  logic [7:0] fifo_q,
  input  logic       fifo_empty,
  input  logic       fifo_full,
  input  logic [7:0] fifo_usedw,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy,
  output logic       overflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [8:0] BURST_LEN_W = 9'(BURST_LEN);
  localparam logic [7:0] GAP_W       = 8'(GAP_CYCLES);

  logic [1:0] r_state;
  logic [8:0] r_len;
  logic [8:0] r_cnt;
  logic [7:0] r_gap_cnt;
  logic       r_rd_req;
  logic       r_out_valid;
  logic       r_out_last;
  logic       r_overflow;
  logic       r_flush_pend;

  logic [8:0] w_occ;
  logic       w_drop;
  logic       w_last_rd;
  logic       w_start;
  logic [8:0] w_start_len;

  // Write path is purely combinational: a byte offered while full is lost.
  assign fifo_wr_req  = in_valid & ~fifo_full;
  assign fifo_wr_data = in_data;
  assign w_drop       = in_valid & fifo_full;

  // usedw wraps to 0 at 256 entries, so full supplies the ninth bit.
  assign w_occ = fifo_full ? 9'd256 : {1'b0, fifo_usedw};

  // The read being issued this cycle is the final one of the burst.
  assign w_last_rd = r_rd_req & (r_cnt == r_len);

  // Burst launch decision in IDLE: a full threshold burst has priority, a
  // pending flush takes whatever is buffered (always < BURST_LEN here).
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_start     = 1'b0;
    w_start_len = BURST_LEN_W;
    if (r_state == S_IDLE) begin
      if (w_occ >= BURST_LEN_W) begin
        w_start = 1'b1;
      end else if (r_flush_pend && !fifo_empty) begin
        w_start     = 1'b1;
        w_start_len = w_occ;
      end
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order or other blocks.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_cnt     <= '0;
      r_gap_cnt <= '0;
      r_rd_req  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state  <= S_BURST;
            r_len    <= w_start_len;
            r_cnt    <= 9'd1;
            r_rd_req <= 1'b1;
          end
        end
        S_BURST: begin
          // The latched length never exceeds occupancy and writes only add
          // entries, so the burst runs to completion without checking empty.
          if (r_cnt == r_len) begin
            r_rd_req <= 1'b0;
            r_cnt    <= '0;
            if (GAP_CYCLES > 0) begin
              r_state   <= S_GAP;
              r_gap_cnt <= 8'd1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 9'd1;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_W) begin
            r_state   <= S_IDLE;
            r_gap_cnt <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_rd_req <= 1'b0;
        end
      endcase
    end
  end

  // Output strobes trail the read request by the FIFO's one-cycle q latency.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_out_valid <= r_rd_req;
      r_out_last  <= w_last_rd;
    end
  end

  // Sticky flags: a drop beats a same-cycle clear; a new flush beats the
  // empty-in-IDLE clear.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_overflow   <= 1'b0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end

      if (flush) begin
        r_flush_pend <= 1'b1;
      end else if ((r_state == S_IDLE) && fifo_empty) begin
        r_flush_pend <= 1'b0;
      end
    end
  end

  assign fifo_rd_req = r_rd_req;
  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
  assign out_data    = fifo_q;
  assign busy        = (r_state != S_IDLE);
  assign overflow    = r_overflow;

endmodule
